bm_rng_out_fifo: RTL and testbench
==================================

# bm_rng_out_fifo

Output buffer directly downstream of `bm_rng`. It captures each `(x0_out, x1_out)` pair on the generator's single-cycle `valid` strobe and stores it in a pair-wide FIFO. It then serialises the pairs onto a 16-bit ready/valid stream in the order x0, then x1. `bm_rng` has no back-pressure input, so a pair that arrives while the FIFO is full is dropped whole and flagged.

## Interface
Parameters:
- `DEPTH`, 16 — FIFO capacity in pairs; must be a power of two, ≥ 2.
- `AW`, 4 — log2(`DEPTH`).

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `in_x0`  in  16  sample x0 from `bm_rng.x0_out`
- `in_x1`  in  16  sample x1 from `bm_rng.x1_out`
- `in_valid`  in  1  pair strobe from `bm_rng.valid`
- `out_data`  out  16  current output word
- `out_valid`  out  1  `out_data` is valid
- `out_ready`  in  1  consumer accepts the word
- `out_last`  out  1  high when `out_data` is x1, the second word of a pair
- `level`  out  AW+1  number of pairs stored, 0..`DEPTH`
- `overflow`  out  1  sticky: at least one pair has been dropped
- `clr_ovf`  in  1  synchronous clear of `overflow` and of `drop_cnt`
- `drop_cnt`  out  16  number of dropped pairs; exists only with `BM_FIFO_DROP_CNT_EN`

## Operation
- Storage: `DEPTH` × 32-bit entries, packed as `{x1, x0}`. Pointers are `wr_ptr` and `rd_ptr`, each AW+1 bits with a wrap bit.
  - `empty` = (`wr_ptr == rd_ptr`).
  - `full` = (MSBs differ and low bits are equal).
- Push: on a posedge with `in_valid = 1` and `!full`, write `{in_x1, in_x0}` at `wr_ptr[AW-1:0]` and increment `wr_ptr`.
- Drop: on a posedge with `in_valid = 1` and `full`, write nothing and set `overflow`. The pair is discarded atomically; a single half is never kept.
- Full/pop interaction: `full` is evaluated before the same-cycle pop. A push into a full FIFO is therefore dropped even when a pop occurs on that edge.
- Output serialiser, one state bit `half` (0 = x0, 1 = x1):
  - `out_valid` = `!empty`.
  - `out_data` = `half ? mem[rd].x1 : mem[rd].x0`.
  - `out_last` = `half & !empty`.
- Word transfer (`out_valid & out_ready`):
  - `half == 0`: set `half` to 1.
  - `half == 1`: clear `half` and increment `rd_ptr`. The pair is popped here.
- `level` = `wr_ptr - rd_ptr`, counted modulo 2^(AW+1). A pair counts as stored until its x1 word is accepted.
- `out_ready` while `out_valid = 0` has no effect.
- `clr_ovf = 1`: `overflow` ← 0 and `drop_cnt` ← 0 on the next posedge. If a drop happens in the same cycle, the drop wins: `overflow` = 1 and `drop_cnt` = 1.
- Reset, including mid-operation: both pointers ← 0, `half` ← 0, `overflow` ← 0, `drop_cnt` ← 0. Memory contents are not cleared and are unobservable while the FIFO is empty.
- Output values while `reset` is asserted: `out_valid` = 0, `out_last` = 0, `level` = 0, `overflow` = 0, `drop_cnt` = 0. `out_data` is don't-care while `out_valid` = 0.

## Timing
- Every state element updates on the posedge of `clk`; `reset` acts asynchronously.
- Push latency: a pair strobed at edge N produces `out_valid = 1` after edge N, i.e. visible in cycle N+1 when the FIFO was empty. `level` updates after the same edge.
- With `out_ready` held at 1, a pair drains in 2 cycles. Maximum sustained throughput is one pair per 2 cycles.
  - This exceeds the `bm_rng` output rate, so no drops occur under continuous `out_ready = 1`.
- `out_data`, `out_valid` and `out_last` are combinational from registers and memory; there is no path from `out_ready` to them.
- `half` persists across stalls. `out_data` must stay stable while `out_valid & !out_ready`.

## Configuration
- `BM_FIFO_DROP_CNT_EN` defined: a 16-bit `drop_cnt` register exists.
  - It increments on every drop and saturates at 0xFFFF.
  - It is cleared by `reset` and by `clr_ovf`.
- `BM_FIFO_DROP_CNT_EN` undefined: the `drop_cnt` port and its register are absent. Only the sticky `overflow` flag is provided.

## Test plan
- Single pair: after reset, strobe x0 = 0x1234, x1 = 0xABCD with `out_ready = 1`.
  - `out_data` = 0x1234 with `out_last = 0`, then 0xABCD with `out_last = 1`.
  - `level` goes 0 → 1 → 0.
- Stall: strobe one pair, hold `out_ready = 0` for 5 cycles, then raise it.
  - `out_data` holds 0x1234 for the whole stall; x1 follows one cycle after `out_ready` rises.
- Fill and overflow (`DEPTH` = 16, `out_ready = 0`): strobe 18 pairs with x0 = k, x1 = 0x8000 + k for k = 0..17.
  - `level` = 16, `overflow` = 1, `drop_cnt` = 2.
  - Draining yields k = 0..15 only, in order, x0 then x1 for each.
- Full plus simultaneous pop: with the FIFO full and x1 being accepted this cycle, strobe a pair.
  - The pair is dropped, `drop_cnt` increments, and `level` becomes 15.
- Reset mid-drain: assert `reset` with `level` = 5 and `half` = 1.
  - Immediately: `out_valid` = 0, `level` = 0, `overflow` = 0.
  - The next strobed pair is output starting with its x0.
- Clear vs drop: `clr_ovf = 1` in the same cycle as a drop gives `overflow` = 1 and `drop_cnt` = 1.
  - `clr_ovf = 1` alone clears both to 0.

Source files
------------

// File: rtl/bm_rng_out_fifo.sv
// bm_rng_out_fifo
// Pair-wide FIFO behind bm_rng. Each (x0, x1) pair is captured on the
// generator's valid strobe. Pairs are replayed as a 16-bit ready/valid
// stream, x0 first and then x1. The generator cannot be stalled, so a pair
// that arrives while the FIFO is full is dropped whole. The drop sets the
// sticky overflow flag.
// Optional feature: define BM_FIFO_DROP_CNT_EN to add a saturating 16-bit
// drop counter and its drop_cnt output port.
module bm_rng_out_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   in_x0,
  input  logic [15:0]   in_x1,
  input  logic          in_valid,
  output logic [15:0]   out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic [AW:0]   level,
  output logic          overflow,
`ifdef BM_FIFO_DROP_CNT_EN
  output logic [15:0]   drop_cnt,
`endif
  input  logic          clr_ovf
);

  // Serialiser phase: which half of the head pair is presented.
  typedef enum logic {
    HALF_X0 = 1'b0,
    HALF_X1 = 1'b1
  } half_t;

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  // Storage, packed as {x1, x0}. It is never reset, because it is only
  // observable while non-empty.
  logic [31:0] mem [DEPTH];

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  half_t       half_q, half_d;
  logic        overflow_q, overflow_d;

  logic        empty;
  logic        full;
  logic        push;
  logic        drop;
  logic        xfer;
  logic        pop;
  logic [31:0] head_pair;

  // Pointer-derived status. The extra MSB separates full from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // full is taken from the registered pointers. A pop on the same edge
  // therefore cannot make room for an incoming pair.
  assign push = in_valid & ~full;
  assign drop = in_valid & full;
  assign xfer = ~empty & out_ready;
  assign pop  = xfer & (half_q == HALF_X1);

  assign head_pair = mem[rd_ptr_q[AW-1:0]];

  // The output stream depends only on registers and memory. There is no
  // path from out_ready to these outputs.
  assign out_valid = ~empty;
  assign out_data  = (half_q == HALF_X1) ? head_pair[31:16] : head_pair[15:0];
  assign out_last  = (half_q == HALF_X1) & ~empty;
  assign level     = wr_ptr_q - rd_ptr_q;
  assign overflow  = overflow_q;

  // Capture an accepted pair into the slot addressed by the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= {in_x1, in_x0};
    end
  end

  // Next-state logic for the pointers, the serialiser phase and the sticky flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    half_d     = half_q;
    overflow_d = overflow_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    if (xfer) begin
      case (half_q)
        HALF_X0: half_d = HALF_X1;
        HALF_X1: begin
          half_d   = HALF_X0;
          rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        default: half_d = HALF_X0;
      endcase
    end

    // If a drop and a clear occur in the same cycle, the drop wins.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  // State register. Reset is asynchronous and may arrive mid-transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      half_q     <= HALF_X0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      half_q     <= half_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef BM_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating drop count. A drop in a clearing cycle restarts the count at 1.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      if (clr_ovf) begin
        drop_cnt_d = 16'd1;
      end else if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end else if (clr_ovf) begin
      drop_cnt_d = 16'd0;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= 16'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_bm_rng_out_fifo.sv
// Directed testbench for bm_rng_out_fifo, using DEPTH = 16.
// Expected values are worked out by hand from the intended behaviour.
// The drop counter checks are present only in the BM_FIFO_DROP_CNT_EN build.
module tb_bm_rng_out_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk;
  logic          reset;
  logic [15:0]   in_x0;
  logic [15:0]   in_x1;
  logic          in_valid;
  logic [15:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [AW:0]   level;
  logic          overflow;
  logic          clr_ovf;
`ifdef BM_FIFO_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  int total = 0;
  int bad   = 0;

  bm_rng_out_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_x0     (in_x0),
    .in_x1     (in_x1),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .level     (level),
    .overflow  (overflow),
`ifdef BM_FIFO_DROP_CNT_EN
    .drop_cnt  (drop_cnt),
`endif
    .clr_ovf   (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report a mismatch; one line per check.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  // Advance one clock; the bench then sits 1 ns past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [15:0] x0, input logic [15:0] x1);
    in_x0    = x0;
    in_x1    = x1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_x0     = '0;
    in_x1     = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;

    // Reset state.
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    step();
    step();
    reset = 1'b0;

    // Single pair. out_ready is already high while the FIFO is empty.
    out_ready = 1'b1;
    step();
    chk("idle_ready_valid", 32'(out_valid), 32'd0);
    strobe(16'h1234, 16'hABCD);
    chk("s1_x0_data", 32'(out_data), 32'h1234);
    chk("s1_x0_last", 32'(out_last), 32'd0);
    chk("s1_level1", 32'(level), 32'd1);
    step();
    chk("s1_x1_data", 32'(out_data), 32'hABCD);
    chk("s1_x1_last", 32'(out_last), 32'd1);
    chk("s1_level_x1", 32'(level), 32'd1);
    step();
    chk("s1_empty", 32'(out_valid), 32'd0);
    chk("s1_level0", 32'(level), 32'd0);

    // Stall for 5 cycles.
    out_ready = 1'b0;
    strobe(16'h1234, 16'hABCD);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_hold%0d", i), {15'd0, out_last, out_data}, 32'h0000_1234);
      step();
    end
    out_ready = 1'b1;
    chk("stall_release_x0", 32'(out_data), 32'h1234);
    step();
    chk("stall_x1", {15'd0, out_last, out_data}, 32'h0001_ABCD);
    step();
    chk("stall_empty", 32'(out_valid), 32'd0);

    // Fill and overflow: 18 pairs into 16 slots.
    out_ready = 1'b0;
    for (int k = 0; k < 18; k++) begin
      strobe(16'(k), 16'(32'h8000 + k));
    end
    chk("fill_level", 32'(level), 32'd16);
    chk("fill_ovf", 32'(overflow), 32'd1);
`ifdef BM_FIFO_DROP_CNT_EN
    chk("fill_dropcnt", 32'(drop_cnt), 32'd2);
`endif
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain%0d_x0", k), {15'd0, out_last, out_data}, 32'(k));
      step();
      chk($sformatf("drain%0d_x1", k), {15'd0, out_last, out_data}, 32'h0001_0000 | 32'(32'h8000 + k));
      step();
    end
    chk("drain_empty", 32'(out_valid), 32'd0);
    chk("drain_level", 32'(level), 32'd0);

    // Full plus a simultaneous pop: the incoming pair is still dropped.
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      strobe(16'(32'h100 + k), 16'(32'h200 + k));
    end
    chk("fp_level16", 32'(level), 32'd16);
    out_ready = 1'b1;
    step();
    chk("fp_half1", 32'(out_last), 32'd1);
    in_x0    = 16'hDEAD;
    in_x1    = 16'hBEEF;
    in_valid = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("fp_level15", 32'(level), 32'd15);
    chk("fp_ovf", 32'(overflow), 32'd1);
`ifdef BM_FIFO_DROP_CNT_EN
    chk("fp_dropcnt", 32'(drop_cnt), 32'd3);
`endif
    chk("fp_next_head", {15'd0, out_last, out_data}, 32'h0000_0101);

    // Drain to level 5 with half = 1: 10 pops plus one x0 word = 21 words.
    out_ready = 1'b1;
    for (int i = 0; i < 21; i++) step();
    out_ready = 1'b0;
    chk("rm_level5", 32'(level), 32'd5);
    chk("rm_half1", {15'd0, out_last, out_data}, 32'h0001_020B);

    // Asynchronous reset in the middle of a cycle.
    reset = 1'b1;
    #1;
    chk("rm_valid", 32'(out_valid), 32'd0);
    chk("rm_level", 32'(level), 32'd0);
    chk("rm_ovf", 32'(overflow), 32'd0);
    chk("rm_last", 32'(out_last), 32'd0);
`ifdef BM_FIFO_DROP_CNT_EN
    chk("rm_dropcnt", 32'(drop_cnt), 32'd0);
`endif
    step();
    reset = 1'b0;
    strobe(16'h5555, 16'h6666);
    chk("rm_post_x0", {15'd0, out_last, out_data}, 32'h0000_5555);
    chk("rm_post_level", 32'(level), 32'd1);
    out_ready = 1'b1;
    step();
    chk("rm_post_x1", {15'd0, out_last, out_data}, 32'h0001_6666);
    step();
    chk("rm_post_empty", 32'(out_valid), 32'd0);

    // A clear in the same cycle as a drop, then a clear alone.
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      strobe(16'(k), 16'(k));
    end
    chk("cd_ovf_before", 32'(overflow), 32'd0);
    strobe(16'h0F0F, 16'hF0F0);
    chk("cd_ovf_set", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    strobe(16'h0F0F, 16'hF0F0);
    chk("cd_drop_wins_ovf", 32'(overflow), 32'd1);
`ifdef BM_FIFO_DROP_CNT_EN
    chk("cd_drop_wins_cnt", 32'(drop_cnt), 32'd1);
`endif
    step();
    clr_ovf = 1'b0;
    chk("cd_clear_ovf", 32'(overflow), 32'd0);
`ifdef BM_FIFO_DROP_CNT_EN
    chk("cd_clear_cnt", 32'(drop_cnt), 32'd0);
`endif
    chk("cd_level_kept", 32'(level), 32'd16);
    step();
    chk("cd_ovf_stays", 32'(overflow), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
